nvme_fifo_wr_arb: RTL and testbench
===================================

# nvme_fifo_wr_arb

Round-robin write-port arbiter that shares one asynchronous FIFO write port among `nreq` packet sources in the write clock domain. It grants one requester at a time and holds the grant until that requester's `last` beat. It never writes while the FIFO is full and tags each entry with the source id and the `last` flag so the read side can demultiplex. It sits directly in front of the FIFO's `write`/`wdata`/`wfull`/`wafull` port.

## Interface
- `nreq`, 4: number of requesters, 2..8.
- `idw`, 2: id width, ceil(log2(`nreq`)), minimum 1.
- `dwidth`, 64: payload width per requester.
- `max_beats`, 16: packet-length limit used for the error check, 1..255.
- `clk` in 1: write-domain clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in `nreq`: requester i has a beat.
- `req_data` in `nreq*dwidth`: payload; slice i is `[i*dwidth +: dwidth]`.
- `req_last` in `nreq`: the beat is the final beat of its packet.
- `req_ready` out `nreq`: a beat is accepted when `req_valid[i]&req_ready[i]`.
- `fifo_write` out 1: connects to the FIFO `write` input.
- `fifo_wdata` out `dwidth+idw+1`: `{last, id, data}`.
- `fifo_wfull` in 1: FIFO `wfull`.
- `fifo_wafull` in 1: FIFO `wafull`.
- `busy` out 1: a grant is held.
- `grant_id` out `idw`: current or last granted requester.
- `err_len` out 1: sticky; a packet exceeded `max_beats`.

## Operation
- State machine with two states:
  - IDLE: no grant is held.
  - GRANT: one requester holds the port.
- IDLE -> GRANT when any `req_valid` is set and `fifo_wafull==0`.
  - The winner is the first set bit searched from `rr_ptr` upward, wrapping modulo `nreq`.
  - The winner is registered into `grant_id`.
  - While `fifo_wafull==1`, the block stays in IDLE and no new packet starts.
- In GRANT:
  - `req_ready[grant_id]` = `~fifo_wfull`; every other `req_ready` is 0.
  - `fifo_write` = `req_valid[grant_id] & ~fifo_wfull`.
  - `fifo_wdata` = `{req_last[g], grant_id, req_data[g]}`, where g = `grant_id`.
- GRANT -> IDLE on an accepted beat with `req_last=1`; on that transition `rr_ptr` <= `grant_id+1` mod `nreq`.
- `fifo_wafull` is ignored inside a packet. Only `fifo_wfull` throttles, so a packet already started always completes.
- The granted requester may drop `req_valid` mid-packet. The grant is held indefinitely and no other requester is served.
- Beat counter `beat_cnt`, 8 bits:
  - Cleared on entry to GRANT.
  - Incremented on each accepted beat, saturating at 255.
  - `err_len` is set when a beat is accepted with `beat_cnt==max_beats`, i.e. the (`max_beats`+1)-th beat.
  - The beat is still written. `err_len` clears only on reset.
- `fifo_write` is never asserted while `fifo_wfull==1`, so no data is silently dropped.

## Timing
- Reset values:
  - State IDLE, `rr_ptr`=0, `grant_id`=0, `beat_cnt`=0, `err_len`=0.
  - `busy`=0, `req_ready`=0, `fifo_write`=0, `fifo_wdata`=0.
- `fifo_write`, `fifo_wdata` and `req_ready` are combinational from registered state and the current inputs, with no added latency.
  - The integration must keep this path short because `fifo_wfull` is a registered FIFO output.
- Arbitration costs 1 cycle:
  - A request seen in IDLE at cycle n is granted at n+1.
  - The first beat can be written at n+1.
- The cycle after a `last` beat is IDLE, so there is a 1-cycle gap between packets. Maximum throughput is L/(L+1) for packets of L beats.
- `busy` = (state==GRANT), registered.
- Reset assertion mid-packet: all state clears immediately and asynchronously, and any partial packet already in the FIFO stays there. The FIFO reset is owned by the integration.
- Deassertion of `reset_n` must be synchronised to `clk` externally.

## Test plan
- Single requester 0 sends a 3-beat packet, FIFO empty:
  - Grant at cycle 1.
  - 3 writes on consecutive cycles, `fifo_wdata[last]` set on the 3rd only.
  - `busy` falls after the 3rd write, `rr_ptr`=1.
- All 4 requesters hold 1-beat packets continuously:
  - Grant order 0,1,2,3,0.
  - One write every 2 cycles.
  - The id field matches the grant order.
- `fifo_wfull` asserted for 5 cycles in the middle of a 4-beat packet:
  - `fifo_write`=0 and `req_ready`=0 during those cycles.
  - Exactly 4 writes in total with payload order preserved.
- `fifo_wafull`=1 with requests pending in IDLE:
  - No grant is issued.
  - Release `fifo_wafull`; the grant appears the next cycle.
  - Also assert `fifo_wafull` inside a packet; the packet completes.
- `max_beats`=4 and a 6-beat packet:
  - `err_len` rises after the 5th beat is accepted and stays high.
  - All 6 beats are written.
- `reset_n` pulsed low during beat 2 of a packet:
  - All outputs go to their reset values within the same cycle.
  - After release, requester 0 is granted first.

Source files
------------

// File: rtl/nvme_fifo_wr_arb.sv
// Round-robin arbiter sharing one async-FIFO write port among nreq packet sources.
// A grant is held from the first beat of a packet until its accepted last beat.
module nvme_fifo_wr_arb #(
  parameter int nreq      = 4,
  parameter int idw       = 2,
  parameter int dwidth    = 64,
  parameter int max_beats = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [nreq-1:0]          req_valid,
  input  logic [nreq*dwidth-1:0]   req_data,
  input  logic [nreq-1:0]          req_last,
  output logic [nreq-1:0]          req_ready,
  output logic                     fifo_write,
  output logic [dwidth+idw:0]      fifo_wdata,
  input  logic                     fifo_wfull,
  input  logic                     fifo_wafull,
  output logic                     busy,
  output logic [idw-1:0]           grant_id,
  output logic                     err_len
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state;
  logic [idw-1:0]    rr_ptr;
  logic [7:0]        beat_cnt;
  logic [idw-1:0]    winner;
  logic              found;
  logic [dwidth-1:0] data_arr [nreq];
  logic              g_valid;
  logic              g_last;
  logic [dwidth-1:0] g_data;

  always_comb begin
    for (int i = 0; i < nreq; i++) data_arr[i] = req_data[i*dwidth +: dwidth];
    g_valid = req_valid[grant_id];
    g_last  = req_last[grant_id];
    g_data  = data_arr[grant_id];
  end

  // First pass covers rr_ptr..nreq-1, second pass wraps around to 0.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < nreq; i++) begin
      if (!found && req_valid[i] && (idw'(i) >= rr_ptr)) begin
        winner = idw'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < nreq; i++) begin
      if (!found && req_valid[i]) begin
        winner = idw'(i);
        found  = 1'b1;
      end
    end
  end

  // Handshake: a beat transfers in the cycle where req_valid[i] & req_ready[i];
  // only the granted requester sees ready, and only while the FIFO is not full.
  always_comb begin
    req_ready  = '0;
    fifo_write = 1'b0;
    fifo_wdata = '0;
    if (state == GRANT) begin
      req_ready[grant_id] = ~fifo_wfull;
      fifo_write          = g_valid & ~fifo_wfull;
      fifo_wdata          = {g_last, grant_id, g_data};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      err_len  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found && !fifo_wafull) begin
            state    <= GRANT;
            busy     <= 1'b1;
            grant_id <= winner;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          // wafull is deliberately ignored here so a started packet always completes.
          if (fifo_write) begin
            if (beat_cnt != 8'hff) beat_cnt <= beat_cnt + 8'd1;
            if (beat_cnt == 8'(max_beats)) err_len <= 1'b1;
            if (g_last) begin
              state  <= IDLE;
              busy   <= 1'b0;
              rr_ptr <= (grant_id == idw'(nreq-1)) ? '0 : grant_id + idw'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nvme_fifo_wr_arb.sv
// Directed bench for nvme_fifo_wr_arb: scoreboard of expected FIFO entries
// filled as beats are handed over, drained by a write monitor.
module tb_nvme_fifo_wr_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int DW   = 16;
  localparam int MAXB = 4;
  localparam int W    = DW + IDW + 1;

  logic              clk;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_write;
  logic [W-1:0]      fifo_wdata;
  logic              fifo_wfull;
  logic              fifo_wafull;
  logic              busy;
  logic [IDW-1:0]    grant_id;
  logic              err_len;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_writes = 0;
  int rr_model = 0;
  int seq      = 0;
  logic err_exp = 1'b0;

  nvme_fifo_wr_arb #(.nreq(NREQ), .idw(IDW), .dwidth(DW), .max_beats(MAXB)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .fifo_write(fifo_write), .fifo_wdata(fifo_wdata),
    .fifo_wfull(fifo_wfull), .fifo_wafull(fifo_wafull),
    .busy(busy), .grant_id(grant_id), .err_len(err_len)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic bit_at(input logic [NREQ-1:0] v, input int i);
    logic [NREQ-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  task automatic idle_inputs();
    req_valid   = '0;
    req_last    = '0;
    req_data    = '0;
    fifo_wfull  = 1'b0;
    fifo_wafull = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset_n  = 1'b1;
    rr_model = 0;
    err_exp  = 1'b0;
  endtask

  // scoreboard drain: every FIFO write must match the oldest expected entry
  always @(negedge clk) begin
    #2;
    if (fifo_write === 1'b1) begin
      n_writes++;
      check("write_while_full", 64'(fifo_wfull), 64'(0));
      check("sb_pending", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) check("sb_data", 64'(fifo_wdata), 64'(exp_q.pop_front()));
    end
  end

  // One packet from requester id; wafull held for `pre` cycles, wfull for
  // cycles [fs, fs+fl), optionally wafull raised after the first beat.
  task automatic send_pkt(input int id, input int n, input int pre, input int fs, input int fl,
                          input bit mid_af, output int first_acc, output int last_acc);
    int beat;
    int c;
    logic [DW-1:0] d;
    logic lst;
    beat = 0; c = 0; first_acc = -1; last_acc = -1;
    d = DW'(id*4096 + seq);
    while (beat < n && c < 60) begin
      lst         = (beat == n-1);
      req_valid   = NREQ'(1) << id;
      req_last    = lst ? (NREQ'(1) << id) : '0;
      req_data    = '0;
      req_data[id*DW +: DW] = d;
      fifo_wafull = (c < pre) || (mid_af && beat > 0);
      fifo_wfull  = (c >= fs) && (c < fs + fl);
      @(negedge clk);
      check("err_len", 64'(err_len), 64'(err_exp));
      if (c < pre) check("afull_no_grant", 64'(busy), 64'(0));
      if (fifo_wfull) begin
        check("full_write", 64'(fifo_write), 64'(0));
        check("full_ready", 64'(req_ready), 64'(0));
      end
      if (bit_at(req_ready, id)) begin
        exp_q.push_back({lst, IDW'(id), d});
        if (beat == MAXB) err_exp = 1'b1;
        if (first_acc < 0) first_acc = c;
        last_acc = c;
        beat++;
        seq++;
        d = DW'(id*4096 + seq);
      end
      @(posedge clk);
      #1;
      c++;
    end
    idle_inputs();
    rr_model = (id + 1) % NREQ;
    check("pkt_beats", 64'(beat), 64'(n));
  endtask

  // Requesters in mask stream 1-beat packets; expected grant order from an RR model.
  task automatic rr_run(input logic [NREQ-1:0] mask, input int ncyc);
    int cnt[NREQ];
    int ptr;
    int w0;
    logic [NREQ-1:0] acc;
    ptr = rr_model;
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    for (int k = 0; k < ncyc/2; k++) begin
      int w;
      w = -1;
      for (int j = 0; j < NREQ; j++)
        if (w < 0 && bit_at(mask, (ptr + j) % NREQ)) w = (ptr + j) % NREQ;
      exp_q.push_back({1'b1, IDW'(w), DW'(w*4096 + cnt[w])});
      cnt[w]++;
      ptr = (w + 1) % NREQ;
    end
    rr_model = ptr;
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    w0 = n_writes;
    for (int c = 0; c < ncyc; c++) begin
      req_valid = mask;
      req_last  = mask;
      for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'(i*4096 + cnt[i]);
      @(negedge clk);
      acc = req_ready & mask;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (bit_at(acc, i)) cnt[i]++;
    end
    idle_inputs();
    check("rr_writes", 64'(n_writes - w0), 64'(ncyc/2));
  endtask

  initial begin : stim
    int fa;
    int la;
    int w0;
    logic [DW-1:0] d0;
    reset_n = 1'b0;
    idle_inputs();
    do_reset();

    // reset values
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_write", 64'(fifo_write), 64'(0));
    check("rst_wdata", 64'(fifo_wdata), 64'(0));
    check("rst_grant", 64'(grant_id), 64'(0));
    check("rst_err", 64'(err_len), 64'(0));
    @(posedge clk); #1;

    // single 3-beat packet from requester 0
    w0 = n_writes;
    send_pkt(0, 3, 0, 100, 0, 1'b0, fa, la);
    check("p3_first", 64'(fa), 64'(1));
    check("p3_last", 64'(la), 64'(3));
    check("p3_writes", 64'(n_writes - w0), 64'(3));
    @(negedge clk);
    check("p3_busy_fall", 64'(busy), 64'(0));
    @(posedge clk); #1;

    // rr_ptr now 1: requesters 0 and 1 together -> 1 first
    rr_run(4'b0011, 4);

    // all four requesters streaming from a fresh pointer
    do_reset();
    rr_run(4'b1111, 16);

    // wfull for 5 cycles inside a 4-beat packet
    w0 = n_writes;
    send_pkt(2, 4, 0, 2, 5, 1'b0, fa, la);
    check("full_last", 64'(la), 64'(9));
    check("full_writes", 64'(n_writes - w0), 64'(4));

    // wafull holds off a new packet but not one in progress
    w0 = n_writes;
    send_pkt(1, 3, 3, 100, 0, 1'b1, fa, la);
    check("afull_first", 64'(fa), 64'(4));
    check("afull_last", 64'(la), 64'(6));
    check("afull_writes", 64'(n_writes - w0), 64'(3));

    // over-length packet sets sticky err_len
    w0 = n_writes;
    send_pkt(3, 6, 0, 100, 0, 1'b0, fa, la);
    check("long_writes", 64'(n_writes - w0), 64'(6));
    @(negedge clk);
    check("err_sticky1", 64'(err_len), 64'(1));
    @(posedge clk); #1;
    @(negedge clk);
    check("err_sticky2", 64'(err_len), 64'(1));
    @(posedge clk); #1;

    // reset pulsed during beat 2 of a packet from requester 3
    req_valid = 4'b1000;
    req_data  = '0;
    req_data[3*DW +: DW] = 16'h3aa1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_busy", 64'(busy), 64'(1));
    if (bit_at(req_ready, 3)) exp_q.push_back({1'b0, IDW'(3), 16'h3aa1});
    @(posedge clk); #1;
    req_data[3*DW +: DW] = 16'h3aa2;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_ready", 64'(req_ready), 64'(0));
    check("arst_write", 64'(fifo_write), 64'(0));
    check("arst_wdata", 64'(fifo_wdata), 64'(0));
    check("arst_grant", 64'(grant_id), 64'(0));
    check("arst_err", 64'(err_len), 64'(0));
    idle_inputs();
    @(posedge clk); #1;
    reset_n  = 1'b1;
    err_exp  = 1'b0;
    rr_model = 0;

    // after reset requester 0 wins over 3
    d0 = 16'h0bb0;
    req_valid = 4'b1001;
    req_last  = 4'b1001;
    req_data[0 +: DW]    = d0;
    req_data[3*DW +: DW] = 16'h3bb0;
    @(negedge clk);
    check("post_rst_idle", 64'(busy), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_grant", 64'(grant_id), 64'(0));
    check("post_rst_busy", 64'(busy), 64'(1));
    if (bit_at(req_ready, 0)) exp_q.push_back({1'b1, IDW'(0), d0});
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;

    check("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
